// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_decoder
// Brief   : Oversampling UART receiver with configurable framing, error/break
//           flags and a first-word-fall-through output FIFO.
// Revision: 1.0
// ============================================================================
module uart_frame_decoder #(
    parameter int CLK_FREQ_MHZ = 27,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          clear_errors,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_BITS-1:0]          out_data,
    output logic                          out_parity_err,
    output logic                          out_frame_err,
    output logic                          overflow,
    output logic                          break_detect,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam longint c_SAMPLE_RATE = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
    localparam int c_DIV_RAW = int'((longint'(CLK_FREQ_MHZ) * 64'd1000000 + c_SAMPLE_RATE / 2) / c_SAMPLE_RATE);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_TW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OW      = $clog2(OVERSAMPLE);
    localparam int c_BW      = $clog2(DATA_BITS + 1);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_CW      = c_AW + 1;
    localparam int c_EW      = DATA_BITS + 2;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
    localparam logic [c_OW-1:0] c_HALF_LAST = c_OW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OW-1:0] c_BIT_LAST  = c_OW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [2:0]           r_warm;
    logic [c_TW-1:0]      r_tick_cnt;
    state_t               r_state;
    logic [c_OW-1:0]      r_os_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_par_err, r_frame_err, r_brk_cand, r_stop_idx;
    logic                 r_push, r_break;
    logic [c_EW-1:0]      r_push_data;
    logic [c_EW-1:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 r_overflow;

    logic w_fall, w_tick, w_sample, w_stop_err, w_brk_first, w_brk, w_last_stop;
    logic w_pop, w_full, w_wr;
    logic [c_EW-1:0] w_head;

    // r_warm keeps the edge detector quiet until the pipeline holds real line samples,
    // so a line already low when reset releases is not mistaken for a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_warm    <= 3'b000;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_warm    <= {r_warm[1:0], 1'b1};
        end
    end

    assign w_fall = r_warm[2] & r_rx_prev & ~r_rx_sync;
    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if ((r_state == S_IDLE && w_fall) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_sample    = w_tick && (r_os_cnt == c_BIT_LAST);
    assign w_stop_err  = r_frame_err | ~r_rx_sync;
    assign w_brk_first = (r_shift == '0) && !r_par_bit && !r_rx_sync;
    assign w_brk       = r_stop_idx ? r_brk_cand : w_brk_first;
    assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_brk_cand  <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_break     <= 1'b0;
        end else begin
            r_push  <= 1'b0;
            r_break <= 1'b0;
            if (w_tick && r_state != S_IDLE && r_state != S_BREAK) begin
                r_os_cnt <= (w_sample || (r_state == S_START && r_os_cnt == c_HALF_LAST))
                            ? '0 : r_os_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state  <= S_START;
                        r_os_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_tick && r_os_cnt == c_HALF_LAST) begin
                        r_bit_cnt   <= '0;
                        r_par_bit   <= 1'b0;
                        r_par_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                        r_stop_idx  <= 1'b0;
                        r_state     <= r_rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_DATA_LAST) begin
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= r_rx_sync;
                        r_par_err <= ((^r_shift) ^ r_rx_sync) != (PARITY == 1);
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_sample) begin
                        if (!r_stop_idx) begin
                            r_brk_cand <= w_brk_first;
                        end
                        if (!w_last_stop) begin
                            r_stop_idx  <= 1'b1;
                            r_frame_err <= w_stop_err;
                        end else if (w_brk) begin
                            r_break <= 1'b1;
                            r_state <= S_BREAK;
                        end else begin
                            r_push      <= 1'b1;
                            r_push_data <= {r_shift, r_par_err, w_stop_err};
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    if (r_rx_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_pop  = out_valid & out_ready;
    assign w_full = (r_count == c_FULL);
    assign w_wr   = r_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_push && !w_wr) begin
                r_overflow <= 1'b1;
            end else if (clear_errors) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign out_valid      = (r_count != '0);
    assign out_data       = out_valid ? w_head[c_EW-1:2] : '0;
    assign out_parity_err = out_valid & w_head[1];
    assign out_frame_err  = out_valid & w_head[0];
    assign overflow       = r_overflow;
    assign break_detect   = r_break;
    assign fifo_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// Bench for uart_frame_decoder: serial frames are built from their bit-level definition and
// the popped entries are compared against expectations computed from the framing rules.
module tb_uart_frame_decoder;
    localparam int BIT = 240;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       clear_errors = 1'b0;
    logic       out_ready = 1'b0;
    logic       ready_p = 1'b1;
    logic       clear_p = 1'b0;
    logic       out_valid, out_parity_err, out_frame_err, overflow, break_detect;
    logic [7:0] out_data;
    logic [3:0] fifo_count;
    logic       vp, perrp, ferrp, ovp, brkp;
    logic [7:0] datap;
    logic [3:0] cntp;

    int total = 0;
    int bad = 0;
    int brk_seen = 0;
    bit rand_done = 0;
    logic [9:0] got_q[$];
    logic [9:0] gotp_q[$];

    uart_frame_decoder dut (
        .clk(clk), .reset(reset_n), .uart_rx(rx), .clear_errors(clear_errors),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
        .overflow(overflow), .break_detect(break_detect), .fifo_count(fifo_count)
    );

    uart_frame_decoder #(.PARITY(2)) dut_p (
        .clk(clk), .reset(reset_n), .uart_rx(rx_p), .clear_errors(clear_p),
        .out_ready(ready_p), .out_valid(vp), .out_data(datap),
        .out_parity_err(perrp), .out_frame_err(ferrp),
        .overflow(ovp), .break_detect(brkp), .fifo_count(cntp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) got_q.push_back({out_data, out_parity_err, out_frame_err});
        if (reset_n && vp && ready_p) gotp_q.push_back({datap, perrp, ferrp});
        if (break_detect) brk_seen++;
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not finish within its time budget");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) rx = v;
        else rx_p = v;
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, one stop bit, then idle high.
    task automatic send_frame(input int line, input logic [7:0] data, input int pmode,
                              input logic pbit, input logic stop_val, input int idle);
        drive(line, 1'b0);
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(line, data[i]);
            step(BIT);
        end
        if (pmode != 0) begin
            drive(line, pbit);
            step(BIT);
        end
        drive(line, stop_val);
        step(BIT);
        drive(line, 1'b1);
        step(idle * BIT);
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input int pmode, input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        return (pmode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    task automatic test_reset();
        rx = 1'b0;
        reset_n = 1'b0;
        step(5);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (break_detect !== 1'b0) begin bad++; $display("FAIL reset_break: got %b want 0", break_detect); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
        reset_n = 1'b1;
        out_ready = 1'b1;
        step(2600);
        rx = 1'b1;
        step(500);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL low_out_of_reset_push: got %0d entries want 0", got_q.size()); end
        total++; if (brk_seen != 0) begin bad++; $display("FAIL low_out_of_reset_break: got %0d pulses want 0", brk_seen); end
    endtask

    task automatic test_basic();
        got_q.delete();
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, 1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL basic_count: got %0d entries want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== {8'h55, 2'b00}) begin bad++; $display("FAIL basic_entry: got %h want %h", got_q[0], {8'h55, 2'b00}); end
        end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL basic_fifo_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_parity();
        logic pb;
        for (int k = 0; k < 2; k++) begin
            pb = (k == 0);
            gotp_q.delete();
            send_frame(1, 8'hA5, 2, pb, 1'b1, 1);
            total++; if (gotp_q.size() != 1) begin bad++; $display("FAIL parity_count[%0d]: got %0d entries want 1", k, gotp_q.size()); end
            else begin
                total++;
                if (gotp_q[0] !== {8'hA5, exp_perr(8'hA5, 2, pb), 1'b0}) begin
                    bad++; $display("FAIL parity_entry[%0d]: got %h want %h", k, gotp_q[0], {8'hA5, exp_perr(8'hA5, 2, pb), 1'b0});
                end
            end
        end
    endtask

    task automatic test_frame_err();
        int b0;
        got_q.delete();
        b0 = brk_seen;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL frame_count: got %0d entries want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== {8'h3C, 2'b01}) begin bad++; $display("FAIL frame_entry: got %h want %h", got_q[0], {8'h3C, 2'b01}); end
        end
        total++; if (brk_seen != b0) begin bad++; $display("FAIL frame_no_break: got %0d pulses want 0", brk_seen - b0); end
    endtask

    task automatic test_break();
        int b0;
        got_q.delete();
        b0 = brk_seen;
        rx = 1'b0;
        step(20 * BIT);
        rx = 1'b1;
        step(BIT);
        total++; if (brk_seen - b0 != 1) begin bad++; $display("FAIL break_pulses: got %0d want 1", brk_seen - b0); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL break_push: got %0d entries want 0", got_q.size()); end
        send_frame(0, 8'h41, 0, 1'b0, 1'b1, 1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL after_break_count: got %0d entries want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== {8'h41, 2'b00}) begin bad++; $display("FAIL after_break_entry: got %h want %h", got_q[0], {8'h41, 2'b00}); end
        end
    endtask

    task automatic test_overflow();
        got_q.delete();
        out_ready = 1'b0;
        for (int f = 1; f <= 9; f++) send_frame(0, 8'(f), 0, 1'b0, 1'b1, 0);
        step(10);
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (out_data !== 8'h01) begin bad++; $display("FAIL ovf_head: got %h want 01", out_data); end
        step(5);
        total++; if (out_data !== 8'h01) begin bad++; $display("FAIL ovf_head_hold: got %h want 01", out_data); end
        out_ready = 1'b1;
        step(12);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL drain_count: got %0d entries want 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            total++;
            if (got_q[i] !== {8'(i + 1), 2'b00}) begin bad++; $display("FAIL drain_entry[%0d]: got %h want %h", i, got_q[i], {8'(i + 1), 2'b00}); end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clear_errors = 1'b1;
        step(1);
        clear_errors = 1'b0;
        step(1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    // Back-to-back random frames while the consumer randomly stalls.
    task automatic test_back_to_back();
        logic [9:0] exp_q[$];
        int b0, exp_brk;
        logic [7:0] d;
        logic s;
        got_q.delete();
        b0 = brk_seen;
        exp_brk = 0;
        rand_done = 0;
        fork
            begin
                for (int f = 0; f < 5; f++) begin
                    d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                    s = ($urandom_range(0, 2) != 0);
                    if (d == 8'h00 && !s) exp_brk++;
                    else exp_q.push_back({d, 1'b0, ~s});
                    send_frame(0, d, 0, 1'b0, s, s ? 0 : 1);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    step(1);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        step(20);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d entries want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_entry[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (brk_seen - b0 != exp_brk) begin bad++; $display("FAIL b2b_breaks: got %0d want %0d", brk_seen - b0, exp_brk); end
    endtask

    task automatic test_glitch_reset();
        logic [7:0] d;
        got_q.delete();
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(3 * BIT);
        total++; if (got_q.size() != 0 || fifo_count !== 4'd0) begin bad++; $display("FAIL glitch_push: got %0d entries count %0d want 0", got_q.size(), fifo_count); end
        out_ready = 1'b0;
        send_frame(0, 8'h99, 0, 1'b0, 1'b1, 1);
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL pre_reset_count: got %0d want 1", fifo_count); end
        d = 8'h77;
        rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            step(BIT);
        end
        reset_n = 1'b0;
        rx = 1'b1;
        step(3);
        total++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL in_reset: valid %b count %0d want 0 0", out_valid, fifo_count); end
        reset_n = 1'b1;
        out_ready = 1'b1;
        step(2 * BIT);
        total++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin bad++; $display("FAIL post_reset: valid %b count %0d want 0 0", out_valid, fifo_count); end
        send_frame(0, 8'h12, 0, 1'b0, 1'b1, 1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL post_reset_frames: got %0d entries want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== {8'h12, 2'b00}) begin bad++; $display("FAIL post_reset_entry: got %h want %h", got_q[0], {8'h12, 2'b00}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_break();
        test_overflow();
        test_back_to_back();
        test_glitch_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
